// File: rtl/m_seq_pkg.sv
// Shared definitions for the x^5+x^2+1 M-sequence generator and checker.
package m_seq_pkg;

  localparam int LFSR_W = 5;
  localparam int TAP_A  = 3;
  localparam int TAP_B  = 0;
  localparam logic [LFSR_W-1:0] SEED = 5'b11111;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // Next sequence bit from a register holding b[n] (bit 0) .. b[n+4] (bit 4).
  function automatic logic lfsr_next(input logic [LFSR_W-1:0] r);
    return r[TAP_A] ^ r[TAP_B];
  endfunction

endpackage

// File: rtl/m_seq_if.sv
// Serial-bit and status bundle between the M-sequence checker and its user.
// Handshake: in_bit and clr_cnt are sampled on a rising clk; in_bit is only meaningful
// when in_valid=1 (no backpressure). All outputs are registered and change only after clk edges.
interface m_seq_if
  import m_seq_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_bit;
  logic             clr_cnt;
  logic             locked;
  logic             err;
  logic             lock_lost;
  logic [CNT_W-1:0] err_cnt;
  state_e           dbg_state;

  modport master (
    output in_valid, in_bit, clr_cnt,
    input  locked, err, lock_lost, err_cnt, dbg_state
  );

  modport slave (
    input  in_valid, in_bit, clr_cnt,
    output locked, err, lock_lost, err_cnt, dbg_state
  );
endinterface

// File: rtl/m_seq_shreg.sv
// 5-bit receive shift register: shifts in either the line bit or its own prediction.
module m_seq_shreg
  import m_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic shift_i,
  input  logic sel_pred_i,
  input  logic bit_i,
  output logic pred_o,
  output logic in_nz_o
);

  logic [LFSR_W-1:0] r_q;
  logic [LFSR_W-1:0] r_in;
  logic              new_bit;

  assign pred_o  = lfsr_next(r_q);
  assign new_bit = sel_pred_i ? pred_o : bit_i;
  // Register contents if bit_i were shifted in; used to reject the all-zero lockup state.
  assign r_in    = {bit_i, r_q[LFSR_W-1:1]};
  assign in_nz_o = |r_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (shift_i) begin
      r_q <= {new_bit, r_q[LFSR_W-1:1]};
    end
  end

endmodule

// File: rtl/m_seq_checker.sv
// Self-synchronising M-sequence checker: acquires lock, flywheels, counts errors,
// and drops lock when too many errors land in one window.
module m_seq_checker
  import m_seq_pkg::*;
#(
  parameter int SYNC_OK  = 8,
  parameter int WIN_LEN  = 31,
  parameter int LOSS_THR = 4,
  parameter int CNT_W    = 16
) (
  input logic clk,
  input logic rst,
  m_seq_if.slave bus
);

  localparam int GW  = $clog2(SYNC_OK + 1);
  localparam int WPW = $clog2(WIN_LEN);
  localparam int WEW = $clog2(LOSS_THR + 1);
  localparam logic [2:0]     FILL_MAX  = 3'd5;
  localparam logic [GW-1:0]  SYNC_V    = GW'(SYNC_OK);
  localparam logic [WPW-1:0] WIN_LAST  = WPW'(WIN_LEN - 1);
  localparam logic [WEW-1:0] LOSS_V    = WEW'(LOSS_THR);

  state_e           state_q,    state_d;
  logic [2:0]       fill_q,     fill_d;
  logic [GW-1:0]    good_q,     good_d;
  logic [WPW-1:0]   win_pos_q,  win_pos_d;
  logic [WEW-1:0]   win_err_q,  win_err_d;
  logic             err_q,      err_d;
  logic             lost_q,     lost_d;
  logic [CNT_W-1:0] err_cnt_q,  err_cnt_d;

  logic pred;
  logic in_nz;
  logic mismatch;
  logic wrap;
  logic [WEW-1:0] win_total;

  // In LOCKED the register flywheels on its own prediction so line errors cannot corrupt it.
  m_seq_shreg u_shreg (
    .clk        (clk),
    .rst        (rst),
    .shift_i    (bus.in_valid),
    .sel_pred_i (state_q == LOCKED),
    .bit_i      (bus.in_bit),
    .pred_o     (pred),
    .in_nz_o    (in_nz)
  );

  assign mismatch = bus.in_bit ^ pred;

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    good_d    = good_q;
    win_pos_d = win_pos_q;
    win_err_d = win_err_q;
    err_d     = 1'b0;
    lost_d    = 1'b0;
    wrap      = 1'b0;
    win_total = '0;
    if (bus.in_valid) begin
      case (state_q)
        SEARCH: begin
          fill_d = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 1'b1;
          if (fill_d == FILL_MAX && in_nz) begin
            state_d = VERIFY;
            good_d  = '0;
          end
        end
        VERIFY: begin
          if (!mismatch) begin
            good_d = good_q + 1'b1;
            if (good_d == SYNC_V) begin
              state_d   = LOCKED;
              win_pos_d = '0;
              win_err_d = '0;
            end
          end else begin
            state_d = SEARCH;
            fill_d  = '0;
          end
        end
        LOCKED: begin
          // The wrap bit opens the new window, so its own error counts there.
          wrap      = (win_pos_q == WIN_LAST);
          win_pos_d = wrap ? '0 : win_pos_q + 1'b1;
          win_total = (wrap ? '0 : win_err_q) + WEW'(mismatch);
          win_err_d = win_total;
          err_d     = mismatch;
          if (mismatch && win_total >= LOSS_V) begin
            state_d = SEARCH;
            fill_d  = '0;
            lost_d  = 1'b1;
          end
        end
        default: begin
          state_d = SEARCH;
          fill_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (bus.clr_cnt) begin
      err_cnt_d = '0;
    end else if (err_d && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SEARCH;
      fill_q    <= '0;
      good_q    <= '0;
      win_pos_q <= '0;
      win_err_q <= '0;
      err_q     <= 1'b0;
      lost_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      good_q    <= good_d;
      win_pos_q <= win_pos_d;
      win_err_q <= win_err_d;
      err_q     <= err_d;
      lost_q    <= lost_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.locked    = (state_q == LOCKED);
  assign bus.err       = err_q;
  assign bus.lock_lost = lost_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_m_seq_checker.sv
// Directed bench for m_seq_checker: lock acquisition, flywheel errors, loss of lock,
// window boundaries, gaps, reset and counter clear.
module tb_m_seq_checker;
  import m_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  m_seq_if #(.CNT_W(16)) bus ();

  m_seq_checker #(
    .SYNC_OK  (8),
    .WIN_LEN  (31),
    .LOSS_THR (4),
    .CNT_W    (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests_run = 0;
  int fail_cnt  = 0;
  logic seq [31];
  int gen_idx = 0;
  logic [15:0] exp_q [$];

  // Reference sequence from the recurrence b[n+5] = b[n+3] ^ b[n], seed 11111.
  task automatic build_seq();
    logic [4:0] seed_v;
    seed_v = SEED;
    for (int i = 0; i < 5; i++) seq[i] = seed_v[i];
    for (int i = 5; i < 31; i++) seq[i] = seq[i-2] ^ seq[i-5];
  endtask

  task automatic drive(input logic v, input logic b, input logic c);
    bus.in_valid = v;
    bus.in_bit   = b;
    bus.clr_cnt  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send_gen(input logic flip, input logic clr);
    drive(1'b1, seq[gen_idx] ^ flip, clr);
    gen_idx = (gen_idx + 1) % 31;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    gen_idx = 0;
  endtask

  task automatic lock_up();
    do_reset();
    for (int i = 0; i < 13; i++) send_gen(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0);
    tests_run++;
    if (bus.locked !== 1'b0 || bus.err !== 1'b0 || bus.lock_lost !== 1'b0) begin
      fail_cnt++;
      $display("FAIL reset_flags: locked=%b err=%b lock_lost=%b required 0 0 0",
               bus.locked, bus.err, bus.lock_lost);
    end
    tests_run++;
    if (bus.err_cnt !== 16'd0 || bus.dbg_state !== SEARCH) begin
      fail_cnt++;
      $display("FAIL reset_state: err_cnt=%0d state=%0d required 0 0", bus.err_cnt, bus.dbg_state);
    end
    rst = 1'b0;
  endtask

  task automatic test_clean_lock();
    int errs;
    do_reset();
    for (int i = 1; i <= 13; i++) begin
      send_gen(1'b0, 1'b0);
      if (i == 12) begin
        tests_run++;
        if (bus.locked !== 1'b0) begin
          fail_cnt++;
          $display("FAIL clean_lock_bit12: locked=%b required 0", bus.locked);
        end
      end
    end
    tests_run++;
    if (bus.locked !== 1'b1) begin
      fail_cnt++;
      $display("FAIL clean_lock_bit13: locked=%b required 1", bus.locked);
    end
    errs = 0;
    for (int i = 0; i < 200; i++) begin
      send_gen(1'b0, 1'b0);
      if (bus.err !== 1'b0 || bus.locked !== 1'b1) errs++;
    end
    tests_run++;
    if (errs != 0 || bus.err_cnt !== 16'd0) begin
      fail_cnt++;
      $display("FAIL clean_run: bad_cycles=%0d err_cnt=%0d required 0 0", errs, bus.err_cnt);
    end
  endtask

  task automatic test_single_error();
    int errs;
    lock_up();
    for (int i = 0; i < 5; i++) send_gen(1'b0, 1'b0);
    send_gen(1'b1, 1'b0);
    tests_run++;
    if (bus.err !== 1'b1 || bus.err_cnt !== 16'd1 || bus.locked !== 1'b1) begin
      fail_cnt++;
      $display("FAIL single_err: err=%b err_cnt=%0d locked=%b required 1 1 1",
               bus.err, bus.err_cnt, bus.locked);
    end
    send_gen(1'b0, 1'b0);
    tests_run++;
    if (bus.err !== 1'b0) begin
      fail_cnt++;
      $display("FAIL single_err_pulse: err=%b required 0", bus.err);
    end
    errs = 0;
    for (int i = 0; i < 40; i++) begin
      send_gen(1'b0, 1'b0);
      if (bus.err !== 1'b0) errs++;
    end
    tests_run++;
    if (errs != 0 || bus.err_cnt !== 16'd1 || bus.locked !== 1'b1) begin
      fail_cnt++;
      $display("FAIL single_err_flywheel: errs=%0d err_cnt=%0d locked=%b required 0 1 1",
               errs, bus.err_cnt, bus.locked);
    end
  endtask

  task automatic test_loss_of_lock();
    lock_up();
    for (int p = 0; p <= 9; p++) begin
      send_gen(p == 3 || p == 5 || p == 7 || p == 9, 1'b0);
      if (p == 3 || p == 5 || p == 7) begin
        tests_run++;
        if (bus.err !== 1'b1 || bus.lock_lost !== 1'b0 || bus.locked !== 1'b1) begin
          fail_cnt++;
          $display("FAIL loss_pre p=%0d: err=%b lock_lost=%b locked=%b required 1 0 1",
                   p, bus.err, bus.lock_lost, bus.locked);
        end
      end
    end
    tests_run++;
    if (bus.err !== 1'b1 || bus.lock_lost !== 1'b1 || bus.locked !== 1'b0 ||
        bus.err_cnt !== 16'd4) begin
      fail_cnt++;
      $display("FAIL loss_4th: err=%b lock_lost=%b locked=%b err_cnt=%0d required 1 1 0 4",
               bus.err, bus.lock_lost, bus.locked, bus.err_cnt);
    end
    for (int i = 1; i <= 13; i++) begin
      send_gen(1'b0, 1'b0);
      if (i == 1) begin
        tests_run++;
        if (bus.lock_lost !== 1'b0 || bus.err !== 1'b0) begin
          fail_cnt++;
          $display("FAIL loss_pulse: lock_lost=%b err=%b required 0 0", bus.lock_lost, bus.err);
        end
      end
      if (i == 12) begin
        tests_run++;
        if (bus.locked !== 1'b0) begin
          fail_cnt++;
          $display("FAIL relock_bit12: locked=%b required 0", bus.locked);
        end
      end
    end
    tests_run++;
    if (bus.locked !== 1'b1 || bus.err_cnt !== 16'd4) begin
      fail_cnt++;
      $display("FAIL relock_bit13: locked=%b err_cnt=%0d required 1 4", bus.locked, bus.err_cnt);
    end
  endtask

  task automatic test_window_boundary();
    int drops;
    logic [15:0] exp_v;
    lock_up();
    drops = 0;
    for (int w = 0; w < 5; w++) begin
      for (int p = 0; p < 31; p++) begin
        send_gen(p == 2 || p == 10 || p == 20, 1'b0);
        if (bus.locked !== 1'b1 || bus.lock_lost !== 1'b0) drops++;
      end
      exp_q.push_back(16'(3 * (w + 1)));
      exp_v = exp_q.pop_front();
      tests_run++;
      if (bus.err_cnt !== exp_v) begin
        fail_cnt++;
        $display("FAIL window_cnt w=%0d: err_cnt=%0d required %0d", w, bus.err_cnt, exp_v);
      end
    end
    tests_run++;
    if (drops != 0 || bus.locked !== 1'b1 || bus.err_cnt !== 16'd15) begin
      fail_cnt++;
      $display("FAIL window_hold: drops=%0d locked=%b err_cnt=%0d required 0 1 15",
               drops, bus.locked, bus.err_cnt);
    end
  endtask

  task automatic test_gaps();
    int vcnt;
    int early;
    int cycles;
    do_reset();
    early = 0;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      if (bus.locked !== 1'b0 || bus.dbg_state !== SEARCH) early++;
    end
    tests_run++;
    if (early != 0) begin
      fail_cnt++;
      $display("FAIL all_zero: bad_cycles=%0d required 0", early);
    end
    do_reset();
    vcnt = 0;
    early = 0;
    cycles = 0;
    while (vcnt < 13 && cycles < 400) begin
      if ($urandom_range(0, 1) == 1) begin
        send_gen(1'b0, 1'b0);
        vcnt++;
      end else begin
        drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end
      cycles++;
      if (vcnt < 13 && bus.locked !== 1'b0) early++;
    end
    tests_run++;
    if (vcnt != 13 || early != 0 || bus.locked !== 1'b1) begin
      fail_cnt++;
      $display("FAIL gap_lock: valid=%0d early=%0d locked=%b required 13 0 1",
               vcnt, early, bus.locked);
    end
    for (int i = 0; i < 5; i++) drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    tests_run++;
    if (bus.locked !== 1'b1 || bus.err !== 1'b0 || bus.err_cnt !== 16'd0) begin
      fail_cnt++;
      $display("FAIL gap_hold: locked=%b err=%b err_cnt=%0d required 1 0 0",
               bus.locked, bus.err, bus.err_cnt);
    end
  endtask

  task automatic test_reset_clear();
    lock_up();
    send_gen(1'b1, 1'b0);
    tests_run++;
    if (bus.err !== 1'b1 || bus.err_cnt !== 16'd1) begin
      fail_cnt++;
      $display("FAIL pre_reset: err=%b err_cnt=%0d required 1 1", bus.err, bus.err_cnt);
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.locked !== 1'b0 || bus.err !== 1'b0 || bus.err_cnt !== 16'd0) begin
      fail_cnt++;
      $display("FAIL async_reset: locked=%b err=%b err_cnt=%0d required 0 0 0",
               bus.locked, bus.err, bus.err_cnt);
    end
    drive(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    lock_up();
    send_gen(1'b1, 1'b0);
    send_gen(1'b1, 1'b1);
    tests_run++;
    if (bus.err !== 1'b1 || bus.err_cnt !== 16'd0) begin
      fail_cnt++;
      $display("FAIL clr_with_err: err=%b err_cnt=%0d required 1 0", bus.err, bus.err_cnt);
    end
    send_gen(1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    tests_run++;
    if (bus.err_cnt !== 16'd0 || bus.locked !== 1'b1) begin
      fail_cnt++;
      $display("FAIL clr_no_valid: err_cnt=%0d locked=%b required 0 1", bus.err_cnt, bus.locked);
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
    bus.clr_cnt  = 1'b0;
    build_seq();
    test_reset();
    test_clean_lock();
    test_single_error();
    test_loss_of_lock();
    test_window_boundary();
    test_gaps();
    test_reset_clear();
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
